// File: rtl/sseg_page_arbiter.sv
// Round-robin arbiter that pages one of four 16-bit status sources onto the
// 8-digit seven-segment display for a fixed dwell period per grant.
module sseg_page_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TW          = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic        freeze,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [5:0]  in0,
  output logic [5:0]  in1,
  output logic [5:0]  in2,
  output logic [5:0]  in3,
  output logic [5:0]  in4,
  output logic [5:0]  in5,
  output logic [5:0]  in6,
  output logic [5:0]  in7
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nx;
  logic [1:0]    cur, cur_nx;
  logic [3:0]    pending, pending_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [1:0]    winner;
  logic          found;
  logic [3:0]    ign;
  logic [15:0]   val_cur;

  // First pending channel after cur, wrapping back to cur itself last.
  always_comb begin
    found  = 1'b0;
    winner = cur;
    for (int k = 1; k < 5; k++) begin
      logic [1:0] idx;
      idx = cur + 2'(k);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    timer_nx = timer;
    ign      = 4'b0000;
    case (state)
      IDLE: begin
        if (!freeze && found) begin
          cur_nx   = winner;
          timer_nx = TW'(HOLD_CYCLES - 1);
          state_nx = HOLD;
          ign      = 4'b0001 << winner;
        end
      end
      HOLD: begin
        // The held channel is shown live, so its own ticks are not queued.
        ign = 4'b0001 << cur;
        if (!freeze) begin
          if (timer == '0) state_nx = IDLE;
          else             timer_nx = timer - TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    pending_nx = (pending | req) & ~ign;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur     <= 2'd0;
      pending <= 4'b0000;
      timer   <= '0;
      grant   <= 4'b0001;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cur     <= cur_nx;
      pending <= pending_nx;
      timer   <= timer_nx;
      grant   <= 4'b0001 << cur_nx;
      busy    <= (state_nx == HOLD);
    end
  end

  always_comb begin
    case (cur)
      2'd0:    val_cur = val0;
      2'd1:    val_cur = val1;
      2'd2:    val_cur = val2;
      default: val_cur = val3;
    endcase
  end

  assign in0 = {1'b1, val_cur[3:0],   1'b1};
  assign in1 = {1'b1, val_cur[7:4],   1'b1};
  assign in2 = {1'b1, val_cur[11:8],  1'b1};
  assign in3 = {1'b1, val_cur[15:12], 1'b1};
  assign in4 = 6'b000001;
  assign in5 = 6'b000001;
  assign in6 = 6'b000001;
  // Lit decimal point on the channel digit flags queued updates.
  assign in7 = {1'b1, 2'b00, cur, (pending == 4'b0000)};

endmodule
